// File: rtl/palette_pkg.sv
// Shared widths, fade FSM states and colour helpers for the palette engine.
package palette_pkg;

  localparam int IDX_W_DEF        = 5;
  localparam int CH_W_DEF         = 4;
  localparam int NUM_BANKS_DEF    = 4;
  localparam int FADE_DIV_DEF     = 2;
  localparam int FLASH_PERIOD_DEF = 8;

  localparam int LEVEL_W     = 5;
  localparam int LEVEL_SHIFT = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 5'd0;

  // Widest channel the helpers accept; callers size-cast in and out.
  localparam int CH_MAX    = 8;
  localparam int RGB_MAX_W = 3 * CH_MAX;

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_OUT  = 2'd1,
    FADE_IN   = 2'd2
  } fade_state_t;

  // (c * level) >> 4; level 16 is identity, 0 is black.
  function automatic logic [CH_MAX-1:0] scale_channel(
    input logic [CH_MAX-1:0]  c,
    input logic [LEVEL_W-1:0] level
  );
    logic [CH_MAX+LEVEL_W-1:0] prod;
    prod = {{LEVEL_W{1'b0}}, c} * {{CH_MAX{1'b0}}, level};
    return CH_MAX'(prod >> LEVEL_SHIFT);
  endfunction

  // Packs three ch_w-bit channels as {R,G,B} in the low 3*ch_w bits.
  function automatic logic [RGB_MAX_W-1:0] pack_rgb(
    input logic [CH_MAX-1:0] r,
    input logic [CH_MAX-1:0] g,
    input logic [CH_MAX-1:0] b,
    input int                ch_w
  );
    logic [RGB_MAX_W-1:0] v;
    v = (RGB_MAX_W'(r) << (2 * ch_w)) | (RGB_MAX_W'(g) << ch_w) | RGB_MAX_W'(b);
    return v;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette storage: one write port, one synchronous
// read-first read port.
module palette_ram #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int DATA_W = 12
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rd_data;

  // Write port; contents are loaded by software, never cleared.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port sees the pre-write contents on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/palette_engine.sv
// Banked RGB palette lookup with a two-stage pipeline, frame-timed global
// fade to/from black and bank flashing for frightened ghosts.
module palette_engine
  import palette_pkg::*;
#(
  parameter int IDX_W        = IDX_W_DEF,
  parameter int CH_W         = CH_W_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int FADE_DIV     = FADE_DIV_DEF,
  parameter int FLASH_PERIOD = FLASH_PERIOD_DEF,
  parameter int TRANSP_EN    = 1,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic                pix_valid,
  input  logic [BANK_W-1:0]   pix_bank,
  input  logic [IDX_W-1:0]    pix_index,
  input  logic                flash_en,
  input  logic                fade_req,
  input  logic                fade_dir,
  output logic                fade_busy,
  output logic [4:0]          fade_level,
  output logic                out_valid,
  output logic                out_transparent,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue
);

  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** IDX_W);
  localparam int RGB_W  = 3 * CH_W;
  localparam int FD_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int FL_W   = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  fade_state_t          r_state, w_state_nxt;
  logic [LEVEL_W-1:0]   r_level, w_level_nxt;
  logic [FD_W-1:0]      r_fade_cnt, w_fade_cnt_nxt;
  logic                 w_div_hit;
  logic                 r_busy;

  logic [FL_W-1:0]      r_flash_cnt;
  logic                 r_phase;

  logic [BANK_W-1:0]    w_eff_bank, w_wr_bank;
  logic [ADDR_W-1:0]    w_rd_addr, w_wr_addr;
  logic [RGB_W-1:0]     w_rd_data;

  logic                 r_s1_valid, r_s1_transp;
  logic [LEVEL_W-1:0]   r_s1_level;

  logic [CH_W-1:0]      w_scaled_r, w_scaled_g, w_scaled_b;
  logic [RGB_W-1:0]     w_scaled_rgb;
  logic                 r_out_valid, r_out_transp;
  logic [RGB_W-1:0]     r_rgb;

  // A single palette has no bank bits worth addressing or flashing.
  generate
    if (NUM_BANKS > 1) begin : g_banked
      assign w_eff_bank = flash_en ? (pix_bank ^ BANK_W'(r_phase)) : pix_bank;
      assign w_wr_bank  = wr_bank;
    end else begin : g_single
      assign w_eff_bank = {BANK_W{1'b0}};
      assign w_wr_bank  = {BANK_W{1'b0}};
    end
  endgenerate

  assign w_rd_addr = {w_eff_bank, pix_index};
  assign w_wr_addr = {w_wr_bank, wr_index};

  palette_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (RGB_W)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (wr_rgb),
    .i_rd_en   (pix_valid),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_div_hit = (r_fade_cnt == FD_W'(FADE_DIV - 1));

  // Fade FSM next state; a start pulse does not count a coincident tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_fade_cnt_nxt = r_fade_cnt;
    case (r_state)
      FADE_IDLE: begin
        if (fade_req) begin
          w_state_nxt    = fade_dir ? FADE_IN : FADE_OUT;
          w_fade_cnt_nxt = {FD_W{1'b0}};
        end else begin
          w_state_nxt = FADE_IDLE;
        end
      end
      FADE_OUT: begin
        if (frame_tick) begin
          if (r_level == LEVEL_MIN) begin
            w_state_nxt = FADE_IDLE;
          end else if (w_div_hit) begin
            w_fade_cnt_nxt = {FD_W{1'b0}};
            w_level_nxt    = r_level - 5'd1;
            w_state_nxt    = (r_level == 5'd1) ? FADE_IDLE : FADE_OUT;
          end else begin
            w_fade_cnt_nxt = r_fade_cnt + FD_W'(1);
          end
        end else begin
          w_state_nxt = FADE_OUT;
        end
      end
      FADE_IN: begin
        if (frame_tick) begin
          if (r_level == LEVEL_MAX) begin
            w_state_nxt = FADE_IDLE;
          end else if (w_div_hit) begin
            w_fade_cnt_nxt = {FD_W{1'b0}};
            w_level_nxt    = r_level + 5'd1;
            w_state_nxt    = (r_level == (LEVEL_MAX - 5'd1)) ? FADE_IDLE : FADE_IN;
          end else begin
            w_fade_cnt_nxt = r_fade_cnt + FD_W'(1);
          end
        end else begin
          w_state_nxt = FADE_IN;
        end
      end
      default: begin
        w_state_nxt = FADE_IDLE;
      end
    endcase
  end

  // Fade state, level and step counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= FADE_IDLE;
      r_level    <= LEVEL_MAX;
      r_fade_cnt <= {FD_W{1'b0}};
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_fade_cnt <= w_fade_cnt_nxt;
      r_busy     <= (w_state_nxt != FADE_IDLE);
    end
  end

  // Flash phase toggles every FLASH_PERIOD frames while enabled.
  always_ff @(posedge clk) begin
    if (!reset_n || !flash_en) begin
      r_flash_cnt <= {FL_W{1'b0}};
      r_phase     <= 1'b0;
    end else if (frame_tick) begin
      if (r_flash_cnt == FL_W'(FLASH_PERIOD - 1)) begin
        r_flash_cnt <= {FL_W{1'b0}};
        r_phase     <= ~r_phase;
      end else begin
        r_flash_cnt <= r_flash_cnt + FL_W'(1);
      end
    end
  end

  // Stage 1: alongside the RAM read, capture the level seen by this pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_transp <= 1'b0;
      r_s1_level  <= LEVEL_MIN;
    end else begin
      r_s1_valid <= pix_valid;
      if (pix_valid) begin
        r_s1_transp <= (TRANSP_EN != 0) && (pix_index == {IDX_W{1'b0}});
        r_s1_level  <= r_level;
      end
    end
  end

  assign w_scaled_r = CH_W'(scale_channel(CH_MAX'(w_rd_data[RGB_W-1 -: CH_W]), r_s1_level));
  assign w_scaled_g = CH_W'(scale_channel(CH_MAX'(w_rd_data[2*CH_W-1 -: CH_W]), r_s1_level));
  assign w_scaled_b = CH_W'(scale_channel(CH_MAX'(w_rd_data[CH_W-1:0]), r_s1_level));
  assign w_scaled_rgb = RGB_W'(pack_rgb(CH_MAX'(w_scaled_r), CH_MAX'(w_scaled_g),
                                        CH_MAX'(w_scaled_b), CH_W));

  // Stage 2: scaled colour; outputs hold while no pixel arrives.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_transp <= 1'b0;
      r_rgb        <= {RGB_W{1'b0}};
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_transp <= r_s1_transp;
        r_rgb        <= w_scaled_rgb;
      end
    end
  end

  assign fade_busy       = r_busy;
  assign fade_level      = r_level;
  assign out_valid       = r_out_valid;
  assign out_transparent = r_out_transp;
  assign red             = r_rgb[RGB_W-1 -: CH_W];
  assign green           = r_rgb[2*CH_W-1 -: CH_W];
  assign blue            = r_rgb[CH_W-1:0];

endmodule

// File: doc/palette_engine.md
# palette_engine

Parametrised, writable sprite/tile colour palette for the pacman video path. Holds NUM_BANKS palettes of 2^IDX_W RGB entries in on-chip RAM, and turns a pixel's (bank, index) stream into RGB with a fixed two-cycle pipeline. Adds a frame-timed global fade (to/from black) and a bank-flash mode for frightened-ghost blinking. Sits between the sprite/tile fetch logic and the VGA output register.

## Interface
Parameters:
- IDX_W, 5, colour index width (2^IDX_W entries per bank)
- CH_W, 4, bits per colour channel
- NUM_BANKS, 4, number of palettes (power of two, ≥1); BANK_W = max(1, clog2(NUM_BANKS))
- FADE_DIV, 2, frame ticks per fade level step (≥1)
- FLASH_PERIOD, 8, frame ticks per flash phase (≥1)
- TRANSP_EN, 1, index 0 flagged transparent when 1

Ports (clock and reset first):
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (vsync)
- wr_en  in  1  palette write strobe
- wr_bank  in  BANK_W  write bank
- wr_index  in  IDX_W  write entry
- wr_rgb  in  3*CH_W  {R,G,B} write data
- pix_valid  in  1  lookup request
- pix_bank  in  BANK_W  requested bank
- pix_index  in  IDX_W  requested entry
- flash_en  in  1  enable bank flash
- fade_req  in  1  one-cycle fade start pulse
- fade_dir  in  1  0 = fade out to black, 1 = fade in to full
- fade_busy  out  1  fade in progress
- fade_level  out  5  current level, 0..16
- out_valid  out  1  RGB valid
- out_transparent  out  1  pixel is transparent
- red, green, blue  out  CH_W each  scaled colour

## Operation
- Reset: fade IDLE, fade_level=16, fade_busy=0, flash phase 0, flash/fade tick counters 0, out_valid=0, out_transparent=0, RGB=0. RAM contents not cleared; software loads them.
- Writes: wr_en writes wr_rgb to RAM[wr_bank][wr_index] at clock edge. Read-first: a lookup of the same address in the same cycle returns old data.
- Lookup: effective bank = pix_bank XOR {0…,phase} when flash_en and NUM_BANKS>1, else pix_bank. Stage 1 registers RAM read, valid, transparent flag (TRANSP_EN && pix_index==0), and current fade_level. Stage 2 registers each channel = (c × level) >> 4, computed at CH_W+5 bits, truncated to CH_W; level 16 is identity, 0 is black. out_valid is the stage-2 valid; outputs hold last value when invalid.
- Fade FSM: IDLE, FADE_OUT, FADE_IN. fade_req in IDLE → FADE_OUT (dir 0) or FADE_IN (dir 1), step counter cleared. Each frame_tick increments step counter; on reaching FADE_DIV it clears and level moves by 1 toward 0 (out) or 16 (in). Reaching the target returns to IDLE same edge. fade_req while busy ignored. fade_req toward a level already at target: enter state, return to IDLE on the next tick with no level change. fade_busy = state≠IDLE.
- Flash: with flash_en=1, frame_tick increments flash counter; at FLASH_PERIOD-1 it wraps to 0 and phase toggles. flash_en=0 forces counter and phase to 0.

## Timing
- Lookup latency exactly 2 cycles, fully pipelined, one result per cycle.
- Level and flash phase apply per pixel as sampled in the pix_valid cycle.
- Write visible to a lookup issued the following cycle.
- frame_tick and fade_req coincident in IDLE: fade starts, that tick not counted.
- Reset mid-fade or mid-pipeline: next cycle all outputs at reset values; in-flight pixels dropped.

## Structure
- Package palette_pkg: default widths, LEVEL_MAX=16, fade_state_t enum, rgb packing helper.
- Sub-module palette_ram: NUM_BANKS·2^IDX_W × 3·CH_W simple dual-port, synchronous read-first, one write port, one read port.

## Test plan
- Write bank0 idx5=12'hF80, then lookup → 2 cycles later out_valid=1, red=F, green=8, blue=0.
- Same-cycle write idx3=12'h123 over old 12'hABC with lookup idx3 → ABC; lookup next cycle → 123.
- FADE_DIV=1, fade_req dir0, 8 frame_ticks → fade_level=8, idx5 reads 12'h740; 16 ticks → 000, fade_busy falls; dir1 fade returns to F80.
- FLASH_PERIOD=2, bank0 idx1=00F, bank1 idx1=FFF, flash_en=1, stream bank0 idx1 → 00F for 2 ticks, FFF for 2, repeating; flash_en=0 → 00F.
- Lookup idx0 with TRANSP_EN=1 → out_transparent=1; idx1 → 0.
- reset_n low mid-fade at level 9 with pixels in flight → next cycle fade_level=16, fade_busy=0, out_valid=0.
